// File: rtl/uart_memif_bridge_if.sv
// scarv_ccx_memif: word-wide request/grant memory bus used by the CCX interconnect.
// REQ is the initiator view, RSP the target view.
interface scarv_ccx_memif;
    logic        req;
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic [31:0] rdata;
    logic        error;

    modport REQ (output req, wen, strb, addr, wdata, input gnt, rdata, error);
    modport RSP (input req, wen, strb, addr, wdata, output gnt, rdata, error);
endinterface

// File: rtl/uart_memif_bridge.sv
// UART byte-stream to scarv_ccx_memif bridge: decodes read/write command frames, masters one
// word access each and replies with data and status. UART_MEMIF_BRIDGE_TIMEOUT_EN adds a frame timeout.
module uart_memif_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        g_clk,
    input  logic        g_reset,
    output logic        g_clk_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        busy,
    scarv_ccx_memif.REQ memif
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAddr   = 3'd1;
    localparam logic [2:0] StWdata  = 3'd2;
    localparam logic [2:0] StBusReq = 3'd3;
    localparam logic [2:0] StBusRsp = 3'd4;
    localparam logic [2:0] StTxData = 3'd5;
    localparam logic [2:0] StTxStat = 3'd6;

    localparam logic [7:0] CmdRead  = 8'h01;
    localparam logic [7:0] CmdWrite = 8'h02;

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q;
    logic        write_q;
    logic        bad_q;
    logic        err_q;
    logic        ovr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        cmd_ok;
    logic        in_rx_phase;
    logic        rx_discard;
    logic        tx_go;
    logic        cnt_inc;
    logic        tmo_hit;
    logic [7:0]  stat_byte;

    assign cmd_ok      = (rx_data == CmdRead) || (rx_data == CmdWrite);
    assign in_rx_phase = (state_q == StAddr) || (state_q == StWdata);
    assign rx_discard  = rx_valid && (state_q != StIdle) && !in_rx_phase;
    assign tx_go       = ((state_q == StTxData) || (state_q == StTxStat)) && !tx_busy && !tx_en;
    assign stat_byte   = bad_q ? 8'hFF : {6'b0, ovr_q, err_q};
    assign cnt_inc     = (in_rx_phase && rx_valid) || ((state_q == StTxData) && tx_go);

`ifdef UART_MEMIF_BRIDGE_TIMEOUT_EN
    logic [31:0] tmo_q;

    // Counts idle cycles between bytes; fires on the TIMEOUT_CYCLES-th silent cycle.
    assign tmo_hit = in_rx_phase && !rx_valid && (tmo_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            tmo_q <= '0;
        end else if (rx_valid || !in_rx_phase) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 32'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (rx_valid) state_d = cmd_ok ? StAddr : StTxStat;
            end
            StAddr: begin
                if (tmo_hit) state_d = StIdle;
                else if (rx_valid && cnt_q == 2'd3) state_d = write_q ? StWdata : StBusReq;
            end
            StWdata: begin
                if (tmo_hit) state_d = StIdle;
                else if (rx_valid && cnt_q == 2'd3) state_d = StBusReq;
            end
            StBusReq: begin
                if (memif.gnt) state_d = StBusRsp;
            end
            StBusRsp: state_d = write_q ? StTxStat : StTxData;
            StTxData: begin
                if (tx_go && cnt_q == 2'd3) state_d = StTxStat;
            end
            StTxStat: begin
                if (tx_go) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            write_q <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            state_q <= state_d;
            // Counter restarts at every phase change; a full phase wraps it back to zero anyway.
            if (state_d != state_q) cnt_q <= 2'd0;
            else if (cnt_inc)       cnt_q <= cnt_q + 2'd1;

            tx_en <= tx_go;
            if (tx_go) tx_data <= (state_q == StTxData) ? rdata_q[{cnt_q, 3'b000} +: 8] : stat_byte;

            case (state_q)
                StIdle: begin
                    if (rx_valid) begin
                        write_q <= (rx_data == CmdWrite);
                        bad_q   <= !cmd_ok;
                    end
                end
                StAddr: begin
                    if (rx_valid) addr_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                end
                StWdata: begin
                    if (rx_valid) wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data;
                end
                StBusRsp: begin
                    if (!write_q) rdata_q <= memif.rdata;
                    err_q <= memif.error;
                end
                default: ;
            endcase

            if (state_d == StIdle && state_q != StIdle) ovr_q <= 1'b0;
            else if (rx_discard)                         ovr_q <= 1'b1;
        end
    end

    assign memif.req   = (state_q == StBusReq);
    assign memif.wen   = memif.req && write_q;
    assign memif.strb  = memif.req ? 4'hF : 4'h0;
    assign memif.addr  = addr_q & 32'hFFFF_FFFC;
    assign memif.wdata = wdata_q;

    assign busy      = (state_q != StIdle);
    assign g_clk_req = busy || rx_valid;

endmodule

// File: tb/tb_uart_memif_bridge.sv
// Randomised bench for uart_memif_bridge: frame-level reference model, bus target with stalls
// and errors, and a UART transmitter model that checks the one-pulse-per-byte rule.
module tb_uart_memif_bridge;
    localparam int unsigned TIMEOUT = 100;

    logic       g_clk = 1'b0;
    logic       g_reset = 1'b1;
    logic       g_clk_req;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       busy;

    scarv_ccx_memif mem ();

    uart_memif_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .g_clk_req (g_clk_req),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .memif     (mem)
    );

    always #5 g_clk = ~g_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word memory seen through the bus; unwritten words read back as an address hash.
    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem_arr.exists(k)) return mem_arr[k];
        return k ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [3:0]  strb;
        int          cycles;
        bit          stable;
    } txn_t;

    txn_t       txnq[$];
    logic [7:0] txq[$];
    logic       err_plan   = 1'b0;
    int         stall_plan = 0;

    // Bus target: grants after stall_plan cycles, returns data/error one cycle after grant.
    bit   in_req = 0;
    bit   rsp_pending = 0;
    int   stall_left = 0;
    txn_t cur;
    logic [31:0] rsp_rdata;

    initial begin
        mem.gnt = 1'b0;
        mem.rdata = '0;
        mem.error = 1'b0;
        forever begin
            @(negedge g_clk);
            mem.gnt = 1'b0;
            mem.error = 1'b0;
            mem.rdata = $urandom();
            if (g_reset) begin
                in_req = 0;
                rsp_pending = 0;
            end else if (rsp_pending) begin
                rsp_pending = 0;
                check("req_drop_after_gnt", 32'(mem.req), 32'd0);
                mem.rdata = rsp_rdata;
                mem.error = err_plan;
            end else if (mem.req) begin
                if (!in_req) begin
                    in_req = 1;
                    cur.addr = mem.addr; cur.wdata = mem.wdata;
                    cur.wen = mem.wen; cur.strb = mem.strb;
                    cur.cycles = 0; cur.stable = 1;
                    stall_left = stall_plan;
                end else if (mem.addr !== cur.addr || mem.wdata !== cur.wdata ||
                             mem.wen !== cur.wen || mem.strb !== cur.strb) begin
                    cur.stable = 0;
                end
                cur.cycles++;
                if (stall_left == 0) begin
                    mem.gnt = 1'b1;
                    in_req = 0;
                    txnq.push_back(cur);
                    rsp_pending = 1;
                    rsp_rdata = mem_read(cur.addr);
                end else begin
                    stall_left--;
                end
            end
        end
    end

    // UART transmitter: busy rises the cycle after tx_en and lasts 1..6 cycles.
    int   busy_left = 0;
    bit   tx_pend = 0;
    logic prev_en = 1'b0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge g_clk);
            if (g_reset) begin
                tx_busy = 1'b0; busy_left = 0; tx_pend = 0; prev_en = 1'b0;
            end else begin
                if (tx_en) begin
                    txq.push_back(tx_data);
                    check("tx_en_rule", 32'(tx_busy | prev_en), 32'd0);
                end
                if (tx_pend) begin
                    tx_pend = 0;
                    tx_busy = 1'b1;
                    busy_left = $urandom_range(6, 1);
                end else if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) tx_busy = 1'b0;
                end
                if (tx_en) tx_pend = 1;
                prev_en = tx_en;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge g_clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom());
    endtask

    // inject: 0 none, 1 extra byte while the request is pending, 2 extra byte during read data.
    task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic e, input int stall,
                             input int inject, input bit gaps);
        logic [7:0]  exp_tx[$];
        logic [7:0]  bytes[$];
        logic [31:0] rd;
        logic [7:0]  stat;
        bit          is_rd, is_wr, do_inj2;
        int          waited, nb;
        is_rd = (cmd == 8'h01);
        is_wr = (cmd == 8'h02);
        err_plan = e;
        stall_plan = stall;
        txq.delete();
        txnq.delete();
        rd = mem_read(addr);
        bytes.push_back(cmd);
        if (is_rd || is_wr) for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
        if (is_wr) for (int i = 0; i < 4; i++) bytes.push_back(wdata[8*i +: 8]);
        stat = {6'b0, inject != 0, e};
        if (is_rd) for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        exp_tx.push_back((is_rd || is_wr) ? stat : 8'hFF);

        nb = bytes.size();
        for (int i = 0; i < nb; i++) begin
            send_byte(bytes[i]);
            if (i == 0 && (is_rd || is_wr)) check("clk_req_in_frame", 32'(g_clk_req), 32'd1);
            if (gaps && i != nb - 1) repeat ($urandom_range(2)) @(negedge g_clk);
        end
        if (is_rd || is_wr) check("req_latency", 32'(mem.req), 32'd1);
        if (inject == 1) send_byte(8'($urandom()));
        do_inj2 = (inject == 2);
        waited = 0;
        while (txq.size() < exp_tx.size() && waited < 400) begin
            if (do_inj2 && txq.size() == 1) begin
                send_byte(8'($urandom()));
                do_inj2 = 0;
            end else begin
                @(negedge g_clk);
            end
            waited++;
        end
        check("tx_count", 32'(txq.size()), 32'(exp_tx.size()));
        repeat (10) @(negedge g_clk);
        check("tx_no_extra", 32'(txq.size()), 32'(exp_tx.size()));
        check("busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
            check($sformatf("tx_byte%0d", i), 32'(txq[i]), 32'(exp_tx[i]));

        if (is_rd || is_wr) begin
            check("bus_count", 32'(txnq.size()), 32'd1);
            if (txnq.size() >= 1) begin
                check("bus_addr", txnq[0].addr, {addr[31:2], 2'b00});
                check("bus_wen", 32'(txnq[0].wen), 32'(is_wr));
                check("bus_strb", 32'(txnq[0].strb), 32'hF);
                check("req_cycles", 32'(txnq[0].cycles), 32'(stall + 1));
                check("req_stable", 32'(txnq[0].stable), 32'd1);
                if (is_wr) check("bus_wdata", txnq[0].wdata, wdata);
            end
            if (is_wr && !e) mem_arr[{addr[31:2], 2'b00}] = wdata;
        end else begin
            check("bus_none_bad_cmd", 32'(txnq.size()), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] last_wr;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        last_wr  = 32'h0;
        repeat (3) @(negedge g_clk);
        check("rst_clk_req", 32'(g_clk_req), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mem.req), 32'd0);
        check("rst_wen", 32'(mem.wen), 32'd0);
        check("rst_strb", 32'(mem.strb), 32'd0);
        check("rst_addr", mem.addr, 32'd0);
        check("rst_wdata", mem.wdata, 32'd0);
        #2 g_reset = 1'b0;
        repeat (2) @(negedge g_clk);

        mem_arr[32'h2000_1000] = 32'hDEAD_BEEF;
        run_frame(8'h01, 32'h2000_1000, 32'h0, 1'b0, 0, 0, 0);
        run_frame(8'h02, 32'h0000_0004, 32'h1234_5678, 1'b0, 5, 0, 0);
        run_frame(8'h01, 32'h0000_0004, 32'h0, 1'b0, 1, 0, 1);
        run_frame(8'h01, 32'h8000_0010, 32'h0, 1'b1, 2, 0, 1);
        run_frame(8'h7E, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        run_frame(8'h01, 32'h0000_0123, 32'h0, 1'b0, 2, 2, 1);
        run_frame(8'h02, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 0, 1, 0);

`ifdef UART_MEMIF_BRIDGE_TIMEOUT_EN
        txq.delete();
        txnq.delete();
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (95) @(negedge g_clk);
        check("tmo_still_busy", 32'(busy), 32'd1);
        repeat (10) @(negedge g_clk);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_no_tx", 32'(txq.size()), 32'd0);
        check("tmo_no_bus", 32'(txnq.size()), 32'd0);
        run_frame(8'h01, 32'h2000_1000, 32'h0, 1'b0, 0, 0, 1);
`endif

        // Reset while the bus request is stalled.
        stall_plan = 1000;
        err_plan = 1'b0;
        txq.delete();
        txnq.delete();
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        repeat (2) @(negedge g_clk);
        check("rst_mid_req_before", 32'(mem.req), 32'd1);
        #2 g_reset = 1'b1;
        #1;
        check("rst_mid_req_async", 32'(mem.req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_strb", 32'(mem.strb), 32'd0);
        check("rst_mid_addr", mem.addr, 32'd0);
        @(negedge g_clk);
        #2 g_reset = 1'b0;
        repeat (12) @(negedge g_clk);
        check("rst_mid_no_tx", 32'(txq.size()), 32'd0);
        check("rst_mid_no_bus", 32'(txnq.size()), 32'd0);
        run_frame(8'h02, 32'h0000_0100, 32'h0BAD_F00D, 1'b0, 1, 0, 1);

        for (int f = 0; f < 40; f++) begin
            logic [7:0]  cmd;
            logic [31:0] a, d;
            int          r, inj;
            r = $urandom_range(9);
            a = $urandom();
            d = $urandom();
            if (r < 4) begin
                cmd = 8'h01;
                if ($urandom_range(1) == 1) a = last_wr | 32'($urandom_range(3));
                inj = $urandom_range(2);
            end else if (r < 8) begin
                cmd = 8'h02;
                last_wr = a;
                inj = $urandom_range(1);
            end else begin
                cmd = 8'($urandom());
                if (cmd == 8'h01 || cmd == 8'h02) cmd = 8'h80;
                inj = 0;
            end
            run_frame(cmd, a, d, 1'($urandom_range(3) == 0), $urandom_range(4), inj, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
